serial_word_loader: RTL and testbench

- Loader front end between the UART receiver (8-bit data plus one-cycle strobe) and the write port of the 8K-word program block RAM.
- After reset it decides from the pushbutton whether to run a load or to let the CPU boot immediately.
- In a load it takes a length-prefixed byte stream, packs it into little-endian 32-bit words and issues one write strobe per word.
- It flags completion or error, and a receive timeout catches a stalled host.

---
 rtl/serial_word_loader.sv | 259 +++++++++++++++++++++++++
 tb/tb_serial_word_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// serial_word_loader
//
// Sits between the UART receiver and the write port of the 8K-word program
// block RAM. Shortly after reset it samples the load pushbutton: if pressed it
// accepts a length-prefixed byte stream, packs the bytes into little-endian
// 32-bit words and issues one write strobe per word; otherwise it lets the CPU
// boot straight away.
//
// Stream format: N[7:0], N[15:8], then 4*N data bytes (first byte of a word
// lands in bits [7:0]). With LOADER_CHECKSUM_EN defined, one extra byte
// follows the data: the modulo-256 sum of all data bytes.
//
// Optional feature macro: LOADER_CHECKSUM_EN (undefined by default).
//
// Parameters:
//   ADDR_WIDTH      byte-address width of program memory (word addr = ADDR_WIDTH-2)
//   TIMEOUT_CYCLES  HCLK cycles allowed between bytes once a load has started
//
// Ports:
//   HCLK        in   bus clock
//   resetHW     in   asynchronous active-high reset
//   loadButton  in   pushbutton, asynchronous to HCLK
//   rxByte      in   received byte from the UART
//   newByte     in   one-cycle strobe, rxByte valid
//   wAddr       out  word write address
//   wData       out  word write data
//   wNow        out  one-cycle write enable
//   ROMload     out  loader owns memory, CPU held off
//   loadDone    out  load finished successfully (sticky)
//   loadError   out  load aborted (sticky)
//
// Handshake: the UART side has no back-pressure. A byte is consumed on every
// rising edge where newByte is high; bytes the current state has no use for
// are dropped. The write side is fire-and-forget: wAddr/wData are stable for
// the single cycle wNow is high and the RAM must accept the write then.

module serial_word_loader #(
    parameter int ADDR_WIDTH     = 15,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                  HCLK,
    input  logic                  resetHW,
    input  logic                  loadButton,
    input  logic [7:0]            rxByte,
    input  logic                  newByte,
    output logic [ADDR_WIDTH-3:0] wAddr,
    output logic [31:0]           wData,
    output logic                  wNow,
    output logic                  ROMload,
    output logic                  loadDone,
    output logic                  loadError
);

    localparam int WA = ADDR_WIDTH - 2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_WORDS  = 17'(1) << WA;

    typedef enum logic [2:0] {
        S_CHECK,
        S_BOOT,
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            btn_meta;
    logic            btn_sync;
    logic [1:0]      check_cnt;
    logic [7:0]      hdr_lo;
    logic [WA-1:0]   last_addr;
    logic [1:0]      byte_idx;
    logic [31:0]     pack_reg;
    logic [TW-1:0]   timer;
    logic [7:0]      csum;

    logic [15:0]     count_n;
    logic            timed_state;
    logic            timed_out;
    logic            final_write;
    logic            take_data;
    logic            word_complete;
    logic            last_word_done;

    assign count_n        = {rxByte, hdr_lo};
    assign timed_state    = (state == S_HDR1) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state == S_CSUM)
`endif
                            ;
    assign timed_out      = timed_state && !newByte && (timer == TIMER_LAST);
    // The cycle in which the last word of the image is being written.
    assign final_write    = wNow && (wAddr == last_addr);
    // Bytes arriving during the final write belong to nothing and are dropped.
    assign take_data      = (state == S_DATA) && newByte && !final_write;
    assign word_complete  = take_data && (byte_idx == 2'd3);
    assign last_word_done = word_complete && (wAddr == last_addr);

    // State register
    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            state <= S_CHECK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        ROMload    = 1'b0;
        loadDone   = 1'b0;
        loadError  = 1'b0;
        case (state)
            S_CHECK: begin
                // Third edge after reset release: the synchroniser has had
                // two edges to settle on the real button level.
                if (check_cnt == 2'd2) begin
                    state_next = btn_sync ? S_HDR0 : S_BOOT;
                end
            end
            S_BOOT: begin
                state_next = S_BOOT;
            end
            S_HDR0: begin
                ROMload = 1'b1;
                if (newByte) begin
                    state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                ROMload = 1'b1;
                if (timed_out) begin
                    state_next = S_ERROR;
                end else if (newByte) begin
                    if (count_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end else if ({1'b0, count_n} > MAX_WORDS) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ROMload = 1'b1;
                if (timed_out) begin
                    state_next = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
                end else if (last_word_done) begin
                    // The final wNow pulse is issued while already in CSUM.
                    state_next = S_CSUM;
`else
                end else if (final_write) begin
                    state_next = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                ROMload = 1'b1;
                if (timed_out) begin
                    state_next = S_ERROR;
                end else if (newByte) begin
                    state_next = (rxByte == csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE: begin
                loadDone = 1'b1;
            end
            S_ERROR: begin
                ROMload   = 1'b1;
                loadError = 1'b1;
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase
    end

    // Button synchroniser and decision counter
    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            check_cnt <= 2'd0;
        end else begin
            btn_meta <= loadButton;
            btn_sync <= btn_meta;
            if (state == S_CHECK) begin
                check_cnt <= check_cnt + 2'd1;
            end
        end
    end

    // Inter-byte timeout: restarts on every byte, idle outside timed states
    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            timer <= '0;
        end else if (timed_state && !newByte) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // Header capture, word assembly and write port
    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            hdr_lo    <= 8'd0;
            last_addr <= '0;
            byte_idx  <= 2'd0;
            pack_reg  <= 32'd0;
            csum      <= 8'd0;
            wAddr     <= '0;
            wData     <= 32'd0;
            wNow      <= 1'b0;
        end else begin
            if (wNow) begin
                wNow  <= 1'b0;
                wAddr <= wAddr + 1'b1;
            end
            if ((state == S_HDR0) && newByte) begin
                hdr_lo <= rxByte;
            end
            if ((state == S_HDR1) && newByte) begin
                // Only meaningful when 1 <= N <= 2^WA, where N-1 fits WA bits.
                last_addr <= WA'(count_n - 16'd1);
                byte_idx  <= 2'd0;
                csum      <= 8'd0;
            end
            if (take_data) begin
                byte_idx <= byte_idx + 2'd1;
                csum     <= csum + rxByte;
                pack_reg[{byte_idx, 3'b000} +: 8] <= rxByte;
                // wData is loaded only here, so a byte accepted into
                // pack_reg during the wNow cycle cannot disturb it.
                if (word_complete) begin
                    wData <= {rxByte, pack_reg[23:0]};
                    wNow  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

    localparam int ADDR_WIDTH = 15;
    localparam int TIMEOUT    = 100;
    localparam int WA         = ADDR_WIDTH - 2;
    localparam int W          = WA + 32;

    logic          HCLK       = 1'b0;
    logic          resetHW    = 1'b1;
    logic          loadButton = 1'b0;
    logic [7:0]    rxByte     = 8'd0;
    logic          newByte    = 1'b0;
    logic [WA-1:0] wAddr;
    logic [31:0]   wData;
    logic          wNow;
    logic          ROMload;
    logic          loadDone;
    logic          loadError;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   stream[$];

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    initial begin
        #800000;
        $display("FAIL watchdog: observed no finish, expected finish before 800000");
        $fatal(1, "watchdog");
    end

    serial_word_loader #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .HCLK      (HCLK),
        .resetHW   (resetHW),
        .loadButton(loadButton),
        .rxByte    (rxByte),
        .newByte   (newByte),
        .wAddr     (wAddr),
        .wData     (wData),
        .wNow      (wNow),
        .ROMload   (ROMload),
        .loadDone  (loadDone),
        .loadError (loadError)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: every wNow must match the model ----------------
    always @(negedge HCLK) begin
        if (wNow === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_wnow", 64'(wNow), 64'd0);
            end else begin
                check("write", 64'({wAddr, wData}), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input logic btn);
        @(negedge HCLK);
        resetHW    = 1'b1;
        newByte    = 1'b0;
        loadButton = btn;
        repeat (3) @(negedge HCLK);
        resetHW = 1'b0;
    endtask

    task automatic start_load();
        apply_reset(1'b1);
        repeat (4) @(negedge HCLK);
    endtask

    // Byte is presented from a falling edge and sampled at the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge HCLK);
            newByte = 1'b0;
        end
        @(negedge HCLK);
        newByte = 1'b1;
        rxByte  = b;
    endtask

    task automatic end_stream();
        @(negedge HCLK);
        newByte = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) send_byte(stream[i], $urandom_range(0, max_gap));
        end_stream();
    endtask

    task automatic add_checksum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 2; i < stream.size(); i++) sum = sum + stream[i];
        stream.push_back(sum);
`endif
    endtask

    // Reference model: derives the expected writes and outcome from the
    // stream contents alone.
    task automatic build_expect(output int exp_err);
        int n;
        logic [31:0] word;
        logic [7:0]  sum;
        n = int'({stream[1], stream[0]});
        exp_err = 0;
        if (n > (1 << WA)) begin
            exp_err = 1;
        end else begin
            sum = 8'd0;
            for (int w = 0; w < n; w++) begin
                word = {stream[2+4*w+3], stream[2+4*w+2], stream[2+4*w+1], stream[2+4*w]};
                exp_q.push_back({WA'(w), word});
                sum = sum + word[7:0] + word[15:8] + word[23:16] + word[31:24];
            end
`ifdef LOADER_CHECKSUM_EN
            exp_err = (stream[2+4*n] == sum) ? 0 : 1;
`endif
        end
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (loadDone || loadError) break;
            @(negedge HCLK);
        end
        check("wait_end", 64'(loadDone | loadError), 64'd1);
    endtask

    task automatic check_outcome(input int exp_err);
        wait_end(2000);
        check("load_done",   64'(loadDone),  64'(exp_err == 0));
        check("load_error",  64'(loadError), 64'(exp_err != 0));
        check("romload",     64'(ROMload),   64'(exp_err != 0));
        check("exclusive",   64'(loadDone & loadError), 64'd0);
        check("writes_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int exp_err;
        int n;

        // Reset values
        repeat (2) @(negedge HCLK);
        check("rst_waddr",   64'(wAddr),     64'd0);
        check("rst_wdata",   64'(wData),     64'd0);
        check("rst_wnow",    64'(wNow),      64'd0);
        check("rst_romload", 64'(ROMload),   64'd0);
        check("rst_done",    64'(loadDone),  64'd0);
        check("rst_error",   64'(loadError), 64'd0);

        // Button low: BOOT ignores all traffic for 1000 cycles
        resetHW = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge HCLK);
            newByte = ($urandom_range(0, 3) == 0);
            rxByte  = 8'($urandom);
            if (i % 100 == 99)
                check("boot_quiet", 64'({ROMload, loadDone, loadError}), 64'd0);
        end
        newByte = 1'b0;
        @(negedge HCLK);
        check("boot_wnow", 64'(wNow), 64'd0);

        // Button high: ROMload appears exactly after the third edge
        @(negedge HCLK);
        resetHW    = 1'b1;
        loadButton = 1'b1;
        repeat (3) @(negedge HCLK);
        resetHW = 1'b0;
        repeat (2) @(negedge HCLK);
        check("romload_early", 64'(ROMload), 64'd0);
        @(negedge HCLK);
        check("romload_check", 64'(ROMload), 64'd1);

        // Two-word load
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        add_checksum();
        build_expect(exp_err);
        send_stream(1);
        check_outcome(exp_err);
        check("waddr_after_two", 64'(wAddr), 64'd2);
        // Bytes after completion are ignored
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_stream(0);
        repeat (4) @(negedge HCLK);
        check("done_sticky", 64'({loadDone, loadError, ROMload}), 64'b100);

        // N = 8193: error, no writes
        start_load();
        stream = '{8'h01, 8'h20};
        build_expect(exp_err);
        send_stream(1);
        check_outcome(exp_err);

        // N = 8192: legal, proceeds to DATA, then stalls into the timeout
        start_load();
        stream = '{8'h00, 8'h20};
        send_stream(1);
        repeat (5) @(negedge HCLK);
        check("max_n_no_error", 64'({ROMload, loadError}), 64'b10);
        check_outcome(1);

        // Timeout exactly TIMEOUT edges after the last byte
        start_load();
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (stream[i]) send_byte(stream[i], 1);
        end_stream();
        repeat (TIMEOUT - 1) @(negedge HCLK);
        check("timeout_early", 64'(loadError), 64'd0);
        @(negedge HCLK);
        check("timeout_fire", 64'(loadError), 64'd1);
        check("timeout_romload", 64'(ROMload), 64'd1);

        // Reset in the middle of a word
        start_load();
        stream = '{8'h01, 8'h00, 8'hDE, 8'hAD};
        send_stream(1);
        repeat (3) @(negedge HCLK);
        check("midload_romload", 64'(ROMload), 64'd1);
        #2 resetHW = 1'b1;
        #1;
        check("midreset_outputs", 64'({wNow, ROMload, loadDone, loadError}), 64'd0);
        check("midreset_bus", 64'({wAddr, wData}), 64'd0);
        start_load();
        stream = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_checksum();
        build_expect(exp_err);
        send_stream(1);
        check_outcome(exp_err);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        start_load();
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        build_expect(exp_err);
        send_stream(1);
        check_outcome(0);
        start_load();
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        build_expect(exp_err);
        send_stream(1);
        check_outcome(1);
`endif

        // Random loads, including back-to-back bytes and N = 0
        for (int t = 0; t < 10; t++) begin
            start_load();
            n = (t == 0) ? 0 : $urandom_range(1, 6);
            stream.delete();
            stream.push_back(8'(n));
            stream.push_back(8'(n >> 8));
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
            add_checksum();
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0)
                stream[stream.size()-1] = stream[stream.size()-1] ^ 8'h01;
`endif
            build_expect(exp_err);
            send_stream(2);
            check_outcome(exp_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
